// File: rtl/keypad_pkg.sv
// keypad_pkg: shared types and helpers for the matrix keypad scanner.
//   scan_state_t  - scanner FSM states (SCAN, DEBOUNCE, PRESSED)
//   ROW_ACTIVE    - level of a row input when a key on the driven column is down
//   COL_ACTIVE    - level driven onto the selected column
//   key_index()   - row/column to linear key code
//   idx_width()   - index width for a count of n items, never less than 1
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    PRESSED  = 2'd2
  } scan_state_t;

  localparam logic ROW_ACTIVE = 1'b0;
  localparam logic COL_ACTIVE = 1'b0;

  function automatic int key_index(input int row, input int col, input int ncols);
    return row * ncols + col;
  endfunction

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/key_fifo.sv
// key_fifo: small synchronous FIFO with a sticky overflow flag.
// Shared by the keypad scanner and the UART receive path.
// Ports:
//   clk, rst_n   - clock, asynchronous active-low reset
//   push, din    - write request and data; dropped (and overflow set) when
//                  full unless a pop happens in the same cycle
//   pop          - read request; ignored while empty
//   dout, valid  - head-of-queue data and not-empty flag
//   full         - queue holds DEPTH entries
//   overflow     - sticky, cleared only by reset
// DEPTH must be a power of two so the pointers wrap naturally.
module key_fifo #(
  parameter int W     = 4,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         valid,
  output logic         full,
  output logic         overflow
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_pop;
  logic          do_push;

  assign valid   = (count != '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign dout    = mem[rd_ptr];
  assign do_pop  = pop && valid;
  // A pop in the same cycle frees the slot, so a push into a full queue still lands.
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
      if (push && !do_push) overflow <= 1'b1;
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: scans a NUM_ROWS x NUM_COLS matrix keypad one column at a
// time, debounces a single key, and queues its code (row*NUM_COLS+col).
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   col_drv     - active-low one-hot column drive (all ones in reset)
//   row_in      - raw active-low row inputs, synchronised internally
//   key_code    - head-of-queue key code
//   key_valid   - queue not empty
//   key_ready   - consumer accepts key_code
//   key_held    - a debounced key is currently down
//   overflow    - sticky: a code was dropped because the queue was full
// Optional build macro KEYPAD_AUTOREPEAT_EN adds REPEAT_DELAY/REPEAT_RATE
// (in samples): a held key is re-pushed after REPEAT_DELAY consecutive low
// samples, then every REPEAT_RATE samples.
//
// state    | meaning
// ---------+----------------------------------------------------------
// SCAN     | rotating columns, looking for any low row at each sample
// DEBOUNCE | column frozen, counting consecutive low samples of cand_row
// PRESSED  | key accepted and held; counting high samples for release
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int NUM_ROWS     = 4,
  parameter int NUM_COLS     = 3,
  parameter int SCAN_DIV     = 10000,
  parameter int DEBOUNCE_CNT = 4,
  parameter int FIFO_DEPTH   = 4,
`ifdef KEYPAD_AUTOREPEAT_EN
  parameter int REPEAT_DELAY = 50,
  parameter int REPEAT_RATE  = 10,
`endif
  localparam int KW = $clog2(NUM_ROWS * NUM_COLS)
) (
  input  logic                clk,
  input  logic                rst_n,
  output logic [NUM_COLS-1:0] col_drv,
  input  logic [NUM_ROWS-1:0] row_in,
  output logic [KW-1:0]       key_code,
  output logic                key_valid,
  input  logic                key_ready,
  output logic                key_held,
  output logic                overflow
);

  localparam int RW = idx_width(NUM_ROWS);
  localparam int CW = idx_width(NUM_COLS);
  localparam int SW = idx_width(SCAN_DIV);
  localparam int DW = idx_width(DEBOUNCE_CNT);

  logic [NUM_ROWS-1:0] row_meta;
  logic [NUM_ROWS-1:0] row_sync;
  logic [SW-1:0]       dwell_cnt;
  logic                sample;
  logic [CW-1:0]       col_idx;
  logic [CW-1:0]       col_inc;
  logic [CW-1:0]       col_sel;
  logic                col_adv;
  scan_state_t         state;
  logic [RW-1:0]       cand_row;
  logic [CW-1:0]       cand_col;
  logic [DW-1:0]       match_cnt;
  logic [DW-1:0]       rel_cnt;
  logic                match_done;
  logic                rel_done;
  logic [RW-1:0]       low_row;
  logic                any_low;
  logic                cand_low;
  logic                push_q;
  logic [KW-1:0]       push_code;

`ifdef KEYPAD_AUTOREPEAT_EN
  localparam int RPW = idx_width((REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE);
  logic [RPW-1:0] rpt_cnt;
  logic           rpt_phase;  // 0: waiting out REPEAT_DELAY, 1: repeating at REPEAT_RATE
  logic           rpt_hit;
  assign rpt_hit = rpt_phase ? (rpt_cnt == RPW'(REPEAT_RATE - 1))
                             : (rpt_cnt == RPW'(REPEAT_DELAY - 1));
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_meta <= {NUM_ROWS{~ROW_ACTIVE}};
      row_sync <= {NUM_ROWS{~ROW_ACTIVE}};
    end else begin
      row_meta <= row_in;
      row_sync <= row_meta;
    end
  end

  assign sample = (dwell_cnt == SW'(SCAN_DIV - 1));

  // Lowest-index active row wins: iterate downward so the last hit is the lowest.
  always_comb begin
    low_row = '0;
    any_low = 1'b0;
    for (int r = NUM_ROWS - 1; r >= 0; r--) begin
      if (row_sync[r] == ROW_ACTIVE) begin
        low_row = RW'(r);
        any_low = 1'b1;
      end
    end
  end

  assign cand_low   = (row_sync[cand_row] == ROW_ACTIVE);
  assign match_done = (match_cnt == DW'(DEBOUNCE_CNT - 1));
  assign rel_done   = (rel_cnt == DW'(DEBOUNCE_CNT - 1));
  assign col_inc    = (col_idx == CW'(NUM_COLS - 1)) ? '0 : col_idx + CW'(1);

  always_comb begin
    col_adv = 1'b0;
    if (sample) begin
      unique case (state)
        SCAN:     col_adv = !any_low;
        DEBOUNCE: col_adv = !cand_low;
        PRESSED:  col_adv = !cand_low && rel_done;
        default:  col_adv = 1'b0;
      endcase
    end
  end

  assign col_sel = col_adv ? col_inc : col_idx;

  // cand_row/cand_col are latched no later than the cycle push_q is set,
  // so the code is stable for the push cycle.
  assign push_code = KW'(key_index(int'(cand_row), int'(cand_col), NUM_COLS));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= SCAN;
      dwell_cnt <= '0;
      col_idx   <= '0;
      col_drv   <= '1;
      cand_row  <= '0;
      cand_col  <= '0;
      match_cnt <= '0;
      rel_cnt   <= '0;
      push_q    <= 1'b0;
      key_held  <= 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
      rpt_cnt   <= '0;
      rpt_phase <= 1'b0;
`endif
    end else begin
      push_q    <= 1'b0;
      col_idx   <= col_sel;
      // col_drv is registered from the next column so it lines up with col_idx.
      col_drv   <= {NUM_COLS{~COL_ACTIVE}} ^ (NUM_COLS'(1) << col_sel);
      dwell_cnt <= sample ? '0 : dwell_cnt + SW'(1);
      if (sample) begin
        unique case (state)
          SCAN: begin
            if (any_low) begin
              cand_row  <= low_row;
              cand_col  <= col_idx;
              match_cnt <= DW'(1);
              rel_cnt   <= '0;
`ifdef KEYPAD_AUTOREPEAT_EN
              rpt_cnt   <= '0;
              rpt_phase <= 1'b0;
`endif
              if (DEBOUNCE_CNT == 1) begin
                state    <= PRESSED;
                push_q   <= 1'b1;
                key_held <= 1'b1;
              end else begin
                state <= DEBOUNCE;
              end
            end
          end
          DEBOUNCE: begin
            if (cand_low) begin
              if (match_done) begin
                state    <= PRESSED;
                push_q   <= 1'b1;
                key_held <= 1'b1;
                rel_cnt  <= '0;
`ifdef KEYPAD_AUTOREPEAT_EN
                rpt_cnt   <= '0;
                rpt_phase <= 1'b0;
`endif
              end else begin
                match_cnt <= match_cnt + DW'(1);
              end
            end else begin
              state <= SCAN;
            end
          end
          PRESSED: begin
            if (cand_low) begin
              rel_cnt <= '0;
`ifdef KEYPAD_AUTOREPEAT_EN
              if (rpt_hit) begin
                push_q    <= 1'b1;
                rpt_cnt   <= '0;
                rpt_phase <= 1'b1;
              end else begin
                rpt_cnt <= rpt_cnt + RPW'(1);
              end
`endif
            end else begin
`ifdef KEYPAD_AUTOREPEAT_EN
              rpt_cnt   <= '0;
              rpt_phase <= 1'b0;
`endif
              if (rel_done) begin
                state    <= SCAN;
                key_held <= 1'b0;
                rel_cnt  <= '0;
              end else begin
                rel_cnt <= rel_cnt + DW'(1);
              end
            end
          end
          default: state <= SCAN;
        endcase
      end
    end
  end

  key_fifo #(
    .W     (KW),
    .DEPTH (FIFO_DEPTH)
  ) u_key_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push_q),
    .din      (push_code),
    .pop      (key_ready),
    .dout     (key_code),
    .valid    (key_valid),
    .full     (),
    .overflow (overflow)
  );

endmodule
